// File: rtl/spi_pkg.sv
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared SPI frame-controller state encoding and sizing helpers.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4,
        ST_FIN       = 3'd5
    } spi_state_e;

    // Shared down-counter width; covers both GAP_CYCLES and ACK_TIMEOUT (<= 255).
    localparam int unsigned c_timer_w = 8;

    function automatic int unsigned calc_nbytes(input int unsigned data_w,
                                                input int unsigned spi_w);
        return data_w / spi_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_gap_timer.sv
// ============================================================================
//  Module      : spi_gap_timer
//  Description : Loadable down-counter; expired while the count sits at zero.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_gap_timer
    import spi_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [c_timer_w-1:0] load_val_i,
    output logic                 expired_o
);

    logic [c_timer_w-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/spi_master_frame_ctrl.sv
// ============================================================================
//  Module      : spi_master_frame_ctrl
//  Description : Splits a DATA_WIDTH frame into MSB-first SPI driver transactions.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_master_frame_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SPI_DATA_WIDTH = 8,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned ACK_TIMEOUT    = 16
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic [DATA_WIDTH-1:0]     tx_word,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [DATA_WIDTH-1:0]     rx_word,
    output logic                      spi_start,
    output logic [SPI_DATA_WIDTH-1:0] spi_tx,
    input  logic [SPI_DATA_WIDTH-1:0] spi_rx,
    input  logic                      spi_ready
);

    localparam int unsigned c_nbytes = calc_nbytes(DATA_WIDTH, SPI_DATA_WIDTH);
    localparam int unsigned c_cnt_w  = $clog2(c_nbytes + 1);
    localparam logic [c_timer_w-1:0] c_ack_load = c_timer_w'(ACK_TIMEOUT - 1);
    localparam logic [c_timer_w-1:0] c_gap_load =
        (GAP_CYCLES > 0) ? c_timer_w'(GAP_CYCLES - 1) : '0;

    spi_state_e                state_q;
    logic [DATA_WIDTH-1:0]     tx_sh_q;
    logic [DATA_WIDTH-1:0]     rx_sh_q;
    logic [DATA_WIDTH-1:0]     rx_word_q;
    logic [c_cnt_w-1:0]        cnt_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      err_q;
    logic                      start_q;
    logic [SPI_DATA_WIDTH-1:0] spi_tx_q;

    logic [DATA_WIDTH-1:0]     tx_shift_d;
    logic [DATA_WIDTH-1:0]     rx_shift_d;
    logic                      last_byte;
    logic                      tmr_load;
    logic [c_timer_w-1:0]      tmr_val;
    logic                      tmr_expired;

    assign tx_shift_d = tx_sh_q << SPI_DATA_WIDTH;
    assign rx_shift_d = DATA_WIDTH'({rx_sh_q, spi_rx});
    assign last_byte  = (cnt_q == c_cnt_w'(c_nbytes - 1));

    // The ack window is armed on the edge into START, so the timeout counts from
    // the spi_start cycle itself; the gap window is armed while waiting for done.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = c_ack_load;
        case (state_q)
            ST_IDLE: tmr_load = 1'b1;
            ST_WAIT_DONE: begin
                tmr_load = 1'b1;
                if (GAP_CYCLES != 0) begin
                    tmr_val = c_gap_load;
                end
            end
            ST_GAP:  tmr_load = tmr_expired;
            default: tmr_load = 1'b0;
        endcase
    end

    spi_gap_timer u_timer (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_word_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            spi_tx_q  <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req && spi_ready) begin
                        tx_sh_q  <= tx_word;
                        rx_sh_q  <= '0;
                        cnt_q    <= '0;
                        spi_tx_q <= tx_word[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
                        start_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_START;
                    end
                end
                ST_START: state_q <= ST_WAIT_ACK;
                ST_WAIT_ACK: begin
                    if (!spi_ready) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (tmr_expired) begin
                        err_q   <= 1'b1;
                        state_q <= ST_FIN;
                    end
                end
                ST_WAIT_DONE: begin
                    if (spi_ready) begin
                        tx_sh_q <= tx_shift_d;
                        rx_sh_q <= rx_shift_d;
                        cnt_q   <= cnt_q + 1'b1;
                        if (last_byte) begin
                            // rx_word only moves on success so a timeout leaves it intact.
                            rx_word_q <= rx_shift_d;
                            done_q    <= 1'b1;
                            state_q   <= ST_FIN;
                        end else if (GAP_CYCLES == 0) begin
                            spi_tx_q <= tx_shift_d[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
                            start_q  <= 1'b1;
                            state_q  <= ST_START;
                        end else begin
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (tmr_expired) begin
                        spi_tx_q <= tx_sh_q[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
                        start_q  <= 1'b1;
                        state_q  <= ST_START;
                    end
                end
                ST_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rx_word   = rx_word_q;
    assign spi_start = start_q;
    assign spi_tx    = spi_tx_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_frame_ctrl.sv
// ============================================================================
//  Module      : tb_spi_master_frame_ctrl
//  Description : Two controllers (GAP_CYCLES 2 and 0) against a driver stub.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_spi_master_frame_ctrl;

    localparam int DRV_LOW = 3;   // cycles the stub holds spi_ready low
    localparam int LAT_G2  = 27;  // 4*(3+2) + 3*2 + 1
    localparam int LAT_G0  = 21;  // 4*(3+2) + 0 + 1
    localparam int ERR_CYC = 17;  // spi_start at cycle 1, err 16 clocks later

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] tx_word = '0;
    logic        hold_rdy = 1'b0;
    logic        stub_dead = 1'b0;
    logic [7:0]  rx_xor = '0;
    logic        mon_clr = 1'b0;

    logic [1:0]  busy_o, done_o, err_o, start_o, rdy_m, rdy_w;
    logic [63:0] rxw_o;
    logic [15:0] stx_o, srx_m;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign rdy_w = hold_rdy ? 2'b00 : rdy_m;

    spi_master_frame_ctrl #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8), .GAP_CYCLES(2), .ACK_TIMEOUT(16)) u_dut_g2 (
        .clk(clk), .rst(rst), .req(req), .tx_word(tx_word),
        .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]), .rx_word(rxw_o[31:0]),
        .spi_start(start_o[0]), .spi_tx(stx_o[7:0]), .spi_rx(srx_m[7:0]), .spi_ready(rdy_w[0]));

    spi_master_frame_ctrl #(.DATA_WIDTH(32), .SPI_DATA_WIDTH(8), .GAP_CYCLES(0), .ACK_TIMEOUT(16)) u_dut_g0 (
        .clk(clk), .rst(rst), .req(req), .tx_word(tx_word),
        .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]), .rx_word(rxw_o[63:32]),
        .spi_start(start_o[1]), .spi_tx(stx_o[15:8]), .spi_rx(srx_m[15:8]), .spi_ready(rdy_w[1]));

    // Driver stub: drop ready for DRV_LOW clocks per start, return tx ^ rx_xor.
    int         dcnt [2];
    logic [7:0] echo [2];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_m <= 2'b11;
            srx_m <= '0;
            for (int k = 0; k < 2; k++) begin
                dcnt[k] <= 0;
                echo[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (dcnt[k] != 0) begin
                    dcnt[k] <= dcnt[k] - 1;
                    if (dcnt[k] == 1) begin
                        rdy_m[k]         <= 1'b1;
                        srx_m[k*8 +: 8]  <= echo[k];
                    end
                end else if (start_o[k] && !stub_dead) begin
                    rdy_m[k] <= 1'b0;
                    dcnt[k]  <= DRV_LOW;
                    echo[k]  <= stx_o[k*8 +: 8] ^ rx_xor;
                end
            end
        end
    end

    // Monitor: cycle index since mon_clr, start/done/err bookkeeping.
    int          cyc [2], nstart [2], ndone [2], nerr [2], lat [2], errcyc [2], since_rise [2];
    logic        prev_rdy [2], busy_evt [2];
    logic [7:0]  txlog [2][8];
    int          gaplog [2][8];
    logic [31:0] rxlog [2][4];
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mon_clr) begin
                cyc[k] = 0; nstart[k] = 0; ndone[k] = 0; nerr[k] = 0;
                lat[k] = -1; errcyc[k] = -1; since_rise[k] = 0;
                prev_rdy[k] = rdy_w[k]; busy_evt[k] = 1'b0;
            end else begin
                cyc[k]++;
                if (rdy_w[k] && !prev_rdy[k]) since_rise[k] = 0;
                else since_rise[k]++;
                prev_rdy[k] = rdy_w[k];
                if (start_o[k]) begin
                    if (nstart[k] < 8) begin
                        txlog[k][nstart[k]]  = stx_o[k*8 +: 8];
                        gaplog[k][nstart[k]] = since_rise[k] - 1;
                    end
                    nstart[k]++;
                end
                if (done_o[k]) begin
                    if (ndone[k] < 4) rxlog[k][ndone[k]] = rxw_o[k*32 +: 32];
                    if (ndone[k] == 0) lat[k] = cyc[k];
                    busy_evt[k] = busy_o[k];
                    ndone[k]++;
                end
                if (err_o[k]) begin
                    errcyc[k]   = cyc[k];
                    busy_evt[k] = busy_o[k];
                    nerr[k]++;
                end
            end
        end
    end

    task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d]: got 0x%0h, expected 0x%0h", name, k, act, exp);
        end
    endtask

    task automatic wait_evt(input int budget);
        int n = 0;
        while (!((ndone[0] + nerr[0]) > 0 && (ndone[1] + nerr[1]) > 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL frame_wait: no done/err within %0d cycles", budget);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [31:0] w);
        @(posedge clk); #1;
        mon_clr = 1'b1; req = 1'b1; tx_word = w;
        @(posedge clk); #1;
        mon_clr = 1'b0; req = 1'b0; tx_word = ~w;   // changes while busy must not matter
    endtask

    typedef struct {
        logic [31:0] tx;
        logic [7:0]  xr;
        logic [31:0] exp_rx;
    } vec_t;

    vec_t vecs [4];
    int   exp_lat [2];
    int   exp_gap [2];

    initial begin
        vecs[0] = '{tx: 32'h11223344, xr: 8'h00, exp_rx: 32'h11223344};
        vecs[1] = '{tx: 32'hA5A55A5A, xr: 8'hFF, exp_rx: 32'h5A5AA5A5};
        vecs[2] = '{tx: 32'h01020304, xr: 8'h0F, exp_rx: 32'h0E0D0C0B};
        vecs[3] = '{tx: 32'hDEADBEEF, xr: 8'h3C, exp_rx: 32'hE29182D3};
        exp_lat = '{LAT_G2, LAT_G0};
        exp_gap = '{2, 0};

        // Reset values
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_busy",  k, 64'(busy_o[k]),  64'h0);
            check("rst_done",  k, 64'(done_o[k]),  64'h0);
            check("rst_err",   k, 64'(err_o[k]),   64'h0);
            check("rst_start", k, 64'(start_o[k]), 64'h0);
            check("rst_spitx", k, 64'(stx_o[k*8 +: 8]),  64'h0);
            check("rst_rxw",   k, 64'(rxw_o[k*32 +: 32]), 64'h0);
        end
        @(posedge clk); #1 rst = 1'b1;

        // req while the driver reports not-ready is held off
        @(posedge clk); #1;
        mon_clr = 1'b1; hold_rdy = 1'b1; req = 1'b1; tx_word = 32'hCAFEF00D;
        @(posedge clk); #1 mon_clr = 1'b0;
        repeat (5) @(posedge clk);
        #1 req = 1'b0; hold_rdy = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("holdoff_busy",   k, 64'(busy_o[k]), 64'h0);
            check("holdoff_starts", k, 64'(nstart[k]), 64'd0);
        end

        // Table-driven frames
        for (int v = 0; v < 4; v++) begin
            @(posedge clk); #1 rx_xor = vecs[v].xr;
            start_frame(vecs[v].tx);
            wait_evt(200);
            for (int k = 0; k < 2; k++) begin
                check("rx_word",   k, 64'(rxw_o[k*32 +: 32]), 64'(vecs[v].exp_rx));
                check("done_cnt",  k, 64'(ndone[k]),  64'd1);
                check("err_cnt",   k, 64'(nerr[k]),   64'd0);
                check("start_cnt", k, 64'(nstart[k]), 64'd4);
                check("tx_bytes",  k, 64'({txlog[k][0], txlog[k][1], txlog[k][2], txlog[k][3]}), 64'(vecs[v].tx));
                check("latency",   k, 64'(lat[k]), 64'(exp_lat[k]));
                check("busy_at_done", k, 64'(busy_evt[k]), 64'h1);
                check("busy_after",   k, 64'(busy_o[k]),   64'h0);
                for (int b = 1; b < 4; b++)
                    check("gap_idle", k, 64'(gaplog[k][b]), 64'(exp_gap[k]));
            end
        end

        // Driver never acknowledges: timeout error, rx_word retained
        @(posedge clk); #1 stub_dead = 1'b1; rx_xor = 8'h00;
        start_frame(32'h55667788);
        wait_evt(200);
        for (int k = 0; k < 2; k++) begin
            check("to_err_cnt",  k, 64'(nerr[k]),   64'd1);
            check("to_err_cyc",  k, 64'(errcyc[k]), 64'(ERR_CYC));
            check("to_done_cnt", k, 64'(ndone[k]),  64'd0);
            check("to_starts",   k, 64'(nstart[k]), 64'd1);
            check("to_busy_err", k, 64'(busy_evt[k]), 64'h1);
            check("to_busy_end", k, 64'(busy_o[k]),   64'h0);
            check("to_rx_hold",  k, 64'(rxw_o[k*32 +: 32]), 64'h00000000E29182D3);
        end
        @(posedge clk); #1 stub_dead = 1'b0;

        // Reset during byte 2, then a clean frame from byte 0
        start_frame(32'hAABBCCDD);
        for (int n = 0; n < 100 && nstart[0] < 2; n++) @(posedge clk);
        check("mid_reached_byte2", 0, 64'(nstart[0] >= 2), 64'h1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("mid_rst_busy",  k, 64'(busy_o[k]),  64'h0);
            check("mid_rst_start", k, 64'(start_o[k]), 64'h0);
            check("mid_rst_spitx", k, 64'(stx_o[k*8 +: 8]),   64'h0);
            check("mid_rst_rxw",   k, 64'(rxw_o[k*32 +: 32]), 64'h0);
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("mid_no_done", k, 64'(ndone[k]), 64'd0);
            check("mid_no_err",  k, 64'(nerr[k]),  64'd0);
        end
        start_frame(32'h01020304);
        wait_evt(200);
        for (int k = 0; k < 2; k++) begin
            check("post_rst_rx",    k, 64'(rxw_o[k*32 +: 32]), 64'h01020304);
            check("post_rst_bytes", k, 64'({txlog[k][0], txlog[k][1], txlog[k][2], txlog[k][3]}), 64'h01020304);
            check("post_rst_done",  k, 64'(ndone[k]), 64'd1);
        end

        // req held high with tx_word changing every cycle: back-to-back frames
        for (int c = 0; c < 75; c++) begin
            @(posedge clk); #1;
            mon_clr = (c == 0);
            req     = (c <= 45);
            tx_word = {8'(c), ~8'(c), 8'(c) ^ 8'h5A, 8'hC3};
        end
        for (int k = 0; k < 2; k++)
            check("b2b_first_rx", k, 64'(rxlog[k][0]), 64'h00FF5AC3);
        check("b2b_done_cnt",  0, 64'(ndone[0]),    64'd2);
        check("b2b_second_rx", 0, 64'(rxlog[0][1]), 64'h1CE346C3);
        check("b2b_done_cnt",  1, 64'(ndone[1]),    64'd3);
        check("b2b_second_rx", 1, 64'(rxlog[1][1]), 64'h16E94CC3);
        check("b2b_third_rx",  1, 64'(rxlog[1][2]), 64'h2CD376C3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
